pcie_dma_mem_arbiter: RTL and testbench
=======================================

# pcie_dma_mem_arbiter

Two-requester arbiter that shares the single PCIe DMA memory request port between the PIO RX engine (requester 0) and the DMA master engine (requester 1). Grants are held for a whole burst, up to and including the beat marked `last`. For every accepted beat, the arbiter records the owning requester in a routing FIFO, then steers each memory response back to that requester in order. It sits between the PCIe RX/DMA engines and the system-bus memory bridge.

## Interface
Parameters:
- `DEPTH_LOG2`, default 2: routing FIFO depth is 2^DEPTH_LOG2, which bounds the number of outstanding beats.

Ports:
- `i_clk` in 1: system bus clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_reqN_valid` in 1 (N=0,1): request beat valid.
- `o_reqN_ready` out 1: beat accepted this cycle when valid&ready.
- `i_reqN_write` in 1: 0=read, 1=write.
- `i_reqN_bytes` in 10: byte count (0=1024).
- `i_reqN_addr` in CFG_PCIE_DMAADDR_WIDTH: address.
- `i_reqN_strob` in 8: write byte strobes.
- `i_reqN_data` in 64: write data.
- `i_reqN_last` in 1: last beat of the burst.
- `o_respN_valid` out 1: response for requester N.
- `o_respN_data` out 64: read data (don't-care for writes).
- `o_mem_valid`, `o_mem_write`, `o_mem_bytes`[10], `o_mem_addr`[CFG_PCIE_DMAADDR_WIDTH], `o_mem_strob`[8], `o_mem_data`[64], `o_mem_last`: out, muxed request to memory.
- `i_mem_ready` in 1: memory accepts the beat.
- `i_mem_resp_valid` in 1: one response per accepted beat, in order.
- `i_mem_resp_data` in 64: response data.
- `o_busy` out 1: grant held or FIFO non-empty.
- `o_err_orphan` out 1: sticky; a response arrived while the FIFO was empty.

## Operation
- State is `IDLE` or `GRANT`. The `grant_id` register (1 bit) and the `rr_ptr` register (1 bit) give the preferred requester.
- **IDLE:**
  - All `o_reqN_ready`=0 and `o_mem_valid`=0.
  - If any `i_reqN_valid` is high, go to `GRANT`.
  - `grant_id` becomes the valid requester. If both are valid, `grant_id`=`rr_ptr`.
- **GRANT:**
  - `o_mem_*` = requester `grant_id` fields.
  - `o_mem_valid` = `i_req[g]_valid` & ~fifo_full.
  - `o_req[g]_ready` = `i_mem_ready` & ~fifo_full.
  - The other requester's ready is 0.
  - On an accepted beat (o_mem_valid&i_mem_ready), push `grant_id` into the FIFO.
  - If the accepted beat has `last`=1: go to `IDLE` and set `rr_ptr` = ~`grant_id`.
  - Valid dropping mid-burst does not release the grant.
- **Routing FIFO:**
  - On `i_mem_resp_valid` with the FIFO non-empty: `o_resp[head]_valid`=1, `o_resp[head]_data`=`i_mem_resp_data`, and pop.
  - The other `o_respN_valid` is 0.
  - On `i_mem_resp_valid` with the FIFO empty: drop the response and set `o_err_orphan`.
  - Full: no push is allowed, even if a pop happens in the same cycle. A simultaneous push+pop when not full leaves the count unchanged.
  - Pointers are DEPTH_LOG2 bits with wrap-around. Full/empty come from a (DEPTH_LOG2+1)-bit count.
- `o_busy` = (state==GRANT) | count!=0.
- **Reset (incl. mid-burst):**
  - state=IDLE, `grant_id`=0, `rr_ptr`=0, FIFO count/pointers=0, `o_err_orphan`=0.
  - All outputs are 0.
  - Responses to pre-reset beats arriving after reset raise `o_err_orphan`.

## Timing
- Arbitration latency: 1 cycle from the first `i_reqN_valid` (in IDLE) to `o_mem_valid`.
- Burst beats stream at 1 per cycle while `i_mem_ready`=1 and the FIFO is not full.
- `o_mem_*`, `o_reqN_ready` and `o_respN_*` are combinational from registered state plus inputs. There is no added latency on data or responses.
- After a last beat, the arbiter spends 1 IDLE cycle before the next grant, so the minimum gap between bursts is 1 cycle.
- Reset values of every output are 0.

## Configuration
- `PCIE_DMA_ARB_FIXED_PRIO_EN`:
  - Defined: requester 0 (PIO) always wins simultaneous requests, and `rr_ptr` is held at 0.
  - Undefined (default): round-robin via `rr_ptr` as described.
- Burst locking and response routing are identical in both builds.

## Test plan
- **Single read, requester 0:** req0 valid, last=1, addr=0x0_0800_0010, bytes=4.
  - Cycle+1: `o_mem_valid`=1 with the same fields.
  - Ready → `o_req0_ready`=1.
  - Response data 0xDEADBEEF → `o_resp0_valid`=1, `o_resp1_valid`=0.
- **Simultaneous requests, round-robin:**
  - Both requesters issue 1-beat bursts continuously.
  - Grants alternate 0,1,0,1. Each `o_mem_valid` is separated by 1 idle cycle.
  - With `PCIE_DMA_ARB_FIXED_PRIO_EN`, grants are all 0.
- **Burst lock:**
  - Req1 sends a 4-beat write burst (strob 0xFF, data 1..4). Req0 becomes valid at beat 2.
  - All 4 beats go to memory before req0 is granted.
  - 4 responses return to `o_resp1`.
- **FIFO full (DEPTH_LOG2=2):**
  - 6-beat burst with no responses.
  - After 4 beats, `o_mem_valid`=0 and `o_req_ready`=0.
  - One response arrives → the next beat is accepted 1 cycle later.
- **Interleaved routing:**
  - Req0 1 beat, then req1 1 beat, with responses A, B delayed.
  - A → `o_resp0`, B → `o_resp1`.
- **Orphan and reset:**
  - Response with an empty FIFO → `o_err_orphan`=1 and stays set.
  - `i_rst` mid-burst → next cycle all outputs are 0, `o_busy`=0, `o_err_orphan`=0.

Source files
------------

// File: rtl/pcie_dma_mem_arbiter.sv
// Burst-locked two-requester arbiter for the PCIe DMA memory port, with in-order response routing.
// Define PCIE_DMA_ARB_FIXED_PRIO_EN to let requester 0 always win simultaneous requests.
module pcie_dma_mem_arbiter #(
  parameter int DEPTH_LOG2             = 2,
  parameter int CFG_PCIE_DMAADDR_WIDTH = 36
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_req0_valid,
  output logic                              o_req0_ready,
  input  logic                              i_req0_write,
  input  logic [9:0]                        i_req0_bytes,
  input  logic [CFG_PCIE_DMAADDR_WIDTH-1:0] i_req0_addr,
  input  logic [7:0]                        i_req0_strob,
  input  logic [63:0]                       i_req0_data,
  input  logic                              i_req0_last,
  input  logic                              i_req1_valid,
  output logic                              o_req1_ready,
  input  logic                              i_req1_write,
  input  logic [9:0]                        i_req1_bytes,
  input  logic [CFG_PCIE_DMAADDR_WIDTH-1:0] i_req1_addr,
  input  logic [7:0]                        i_req1_strob,
  input  logic [63:0]                       i_req1_data,
  input  logic                              i_req1_last,
  output logic                              o_resp0_valid,
  output logic [63:0]                       o_resp0_data,
  output logic                              o_resp1_valid,
  output logic [63:0]                       o_resp1_data,
  output logic                              o_mem_valid,
  output logic                              o_mem_write,
  output logic [9:0]                        o_mem_bytes,
  output logic [CFG_PCIE_DMAADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]                        o_mem_strob,
  output logic [63:0]                       o_mem_data,
  output logic                              o_mem_last,
  input  logic                              i_mem_ready,
  input  logic                              i_mem_resp_valid,
  input  logic [63:0]                       i_mem_resp_data,
  output logic                              o_busy,
  output logic                              o_err_orphan
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             rr_q, rr_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] fifo_q, fifo_d;
  logic             orphan_q, orphan_d;

  logic in_grant, full, empty;
  logic sel_valid, sel_last, push, pop, pick, head;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    fifo_d   = fifo_q;
    orphan_d = orphan_q;

    in_grant  = (state_q == S_GRANT);
    full      = (cnt_q == CW'(DEPTH));
    empty     = (cnt_q == '0);
    sel_valid = grant_q ? i_req1_valid : i_req0_valid;
    sel_last  = grant_q ? i_req1_last : i_req0_last;
    head      = fifo_q[rptr_q];
`ifdef PCIE_DMA_ARB_FIXED_PRIO_EN
    pick      = 1'b0;
`else
    pick      = rr_q;
`endif

    o_mem_valid  = in_grant & sel_valid & ~full;
    o_req0_ready = in_grant & ~grant_q & i_mem_ready & ~full;
    o_req1_ready = in_grant & grant_q & i_mem_ready & ~full;

    // Fields are forced to zero outside a grant so idle/reset outputs are all 0
    o_mem_write = 1'b0;
    o_mem_bytes = '0;
    o_mem_addr  = '0;
    o_mem_strob = '0;
    o_mem_data  = '0;
    o_mem_last  = 1'b0;
    if (in_grant) begin
      o_mem_write = grant_q ? i_req1_write : i_req0_write;
      o_mem_bytes = grant_q ? i_req1_bytes : i_req0_bytes;
      o_mem_addr  = grant_q ? i_req1_addr  : i_req0_addr;
      o_mem_strob = grant_q ? i_req1_strob : i_req0_strob;
      o_mem_data  = grant_q ? i_req1_data  : i_req0_data;
      o_mem_last  = sel_last;
    end

    push = o_mem_valid & i_mem_ready;
    pop  = i_mem_resp_valid & ~empty;

    o_resp0_valid = pop & ~head;
    o_resp1_valid = pop & head;
    o_resp0_data  = o_resp0_valid ? i_mem_resp_data : '0;
    o_resp1_data  = o_resp1_valid ? i_mem_resp_data : '0;

    unique case (state_q)
      S_IDLE: begin
        if (i_req0_valid | i_req1_valid) begin
          state_d = S_GRANT;
          grant_d = (i_req0_valid & i_req1_valid) ? pick : i_req1_valid;
        end
      end
      S_GRANT: begin
        if (push & sel_last) begin
          state_d = S_IDLE;
`ifdef PCIE_DMA_ARB_FIXED_PRIO_EN
          rr_d    = 1'b0;
`else
          rr_d    = ~grant_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      fifo_d[wptr_q] = grant_q;
      wptr_d         = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    if (i_mem_resp_valid & empty) orphan_d = 1'b1;

    o_busy       = in_grant | ~empty;
    o_err_orphan = orphan_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      rr_q     <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      fifo_q   <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      fifo_q   <= fifo_d;
      orphan_q <= orphan_d;
    end
  end

endmodule

// File: tb/tb_pcie_dma_mem_arbiter.sv
// Scoreboard bench for pcie_dma_mem_arbiter: expected routed responses
// are queued per accepted beat and checked as responses appear.
module tb_pcie_dma_mem_arbiter;

  localparam int AW = 36;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_req0_valid, i_req0_write, i_req0_last;
  logic [9:0]    i_req0_bytes;
  logic [AW-1:0] i_req0_addr;
  logic [7:0]    i_req0_strob;
  logic [63:0]   i_req0_data;
  logic          i_req1_valid, i_req1_write, i_req1_last;
  logic [9:0]    i_req1_bytes;
  logic [AW-1:0] i_req1_addr;
  logic [7:0]    i_req1_strob;
  logic [63:0]   i_req1_data;
  logic          o_req0_ready, o_req1_ready;
  logic          o_resp0_valid, o_resp1_valid;
  logic [63:0]   o_resp0_data, o_resp1_data;
  logic          o_mem_valid, o_mem_write, o_mem_last;
  logic [9:0]    o_mem_bytes;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    o_mem_strob;
  logic [63:0]   o_mem_data;
  logic          i_mem_ready, i_mem_resp_valid;
  logic [63:0]   i_mem_resp_data;
  logic          o_busy, o_err_orphan;

  typedef struct {
    logic        id;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  pcie_dma_mem_arbiter #(
    .DEPTH_LOG2(2),
    .CFG_PCIE_DMAADDR_WIDTH(AW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req0_write(i_req0_write), .i_req0_bytes(i_req0_bytes),
    .i_req0_addr(i_req0_addr), .i_req0_strob(i_req0_strob),
    .i_req0_data(i_req0_data), .i_req0_last(i_req0_last),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .i_req1_write(i_req1_write), .i_req1_bytes(i_req1_bytes),
    .i_req1_addr(i_req1_addr), .i_req1_strob(i_req1_strob),
    .i_req1_data(i_req1_data), .i_req1_last(i_req1_last),
    .o_resp0_valid(o_resp0_valid), .o_resp0_data(o_resp0_data),
    .o_resp1_valid(o_resp1_valid), .o_resp1_data(o_resp1_data),
    .o_mem_valid(o_mem_valid), .o_mem_write(o_mem_write),
    .o_mem_bytes(o_mem_bytes), .o_mem_addr(o_mem_addr),
    .o_mem_strob(o_mem_strob), .o_mem_data(o_mem_data),
    .o_mem_last(o_mem_last), .i_mem_ready(i_mem_ready),
    .i_mem_resp_valid(i_mem_resp_valid),
    .i_mem_resp_data(i_mem_resp_data),
    .o_busy(o_busy), .o_err_orphan(o_err_orphan)
  );

  always #5 clk = ~clk;

  // Response monitor: every routed response must match the queue head
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] gd;
    #2;
    if (o_resp0_valid || o_resp1_valid) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got r0=%b r1=%b required none",
                 o_resp0_valid, o_resp1_valid);
      end else begin
        e  = sb.pop_front();
        gd = o_resp1_valid ? o_resp1_data : o_resp0_data;
        if ({o_resp0_valid, o_resp1_valid} !== {~e.id, e.id} ||
            gd !== e.data) begin
          errors++;
          $display("FAIL resp_route got r0=%b r1=%b data=%h required id=%0d data=%h",
                   o_resp0_valid, o_resp1_valid, gd, e.id, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    i_req0_valid = 0; i_req0_write = 0; i_req0_last = 0;
    i_req0_bytes = 0; i_req0_addr = 0; i_req0_strob = 0; i_req0_data = 0;
    i_req1_valid = 0; i_req1_write = 0; i_req1_last = 0;
    i_req1_bytes = 0; i_req1_addr = 0; i_req1_strob = 0; i_req1_data = 0;
    i_mem_ready = 0; i_mem_resp_valid = 0; i_mem_resp_data = 0;
  endtask

  task automatic pulse_reset();
    i_rst = 1;
    tick();
    i_rst = 0;
  endtask

  task automatic test_reset();
    i_rst = 1;
    tick();
    tick();
    i_rst = 0;
    #1;
    vectors++;
    if ({o_mem_valid, o_req0_ready, o_req1_ready, o_resp0_valid,
         o_resp1_valid, o_busy, o_err_orphan} !== 7'b0 ||
        o_mem_addr !== '0 || o_mem_data !== '0) begin
      errors++;
      $display("FAIL reset got mv=%b r0=%b r1=%b busy=%b orph=%b required all 0",
               o_mem_valid, o_req0_ready, o_req1_ready, o_busy, o_err_orphan);
    end
  endtask

  task automatic test_single_read();
    i_req0_valid = 1; i_req0_last = 1; i_req0_write = 0;
    i_req0_addr = 36'h0_0800_0010; i_req0_bytes = 10'd4;
    i_mem_ready = 1;
    #1;
    vectors++;
    if (o_mem_valid !== 1'b0 || o_req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got mv=%b rdy=%b required 0 0",
               o_mem_valid, o_req0_ready);
    end
    tick();
    #1;
    vectors++;
    if (o_mem_valid !== 1'b1 || o_mem_addr !== 36'h0_0800_0010 ||
        o_mem_bytes !== 10'd4 || o_mem_write !== 1'b0 ||
        o_mem_last !== 1'b1 || o_req0_ready !== 1'b1 ||
        o_req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_grant got mv=%b addr=%h bytes=%0d r0=%b r1=%b required 1 0800_0010 4 1 0",
               o_mem_valid, o_mem_addr, o_mem_bytes, o_req0_ready, o_req1_ready);
    end
    sb.push_back('{1'b0, 64'hDEADBEEF});
    tick();
    i_req0_valid = 0; i_req0_last = 0;
    #1;
    vectors++;
    if (o_busy !== 1'b1 || o_mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_outstanding got busy=%b mv=%b required 1 0",
               o_busy, o_mem_valid);
    end
    i_mem_resp_valid = 1; i_mem_resp_data = 64'hDEADBEEF;
    tick();
    i_mem_resp_valid = 0;
    #1;
    vectors++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_drained got busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_round_robin();
    logic exp_g;
    pulse_reset();
    i_req0_valid = 1; i_req0_last = 1; i_req0_addr = 36'h100;
    i_req1_valid = 1; i_req1_last = 1; i_req1_addr = 36'h200;
    i_mem_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
`ifdef PCIE_DMA_ARB_FIXED_PRIO_EN
      exp_g = 1'b0;
`else
      exp_g = ((i >> 1) & 1) != 0;
`endif
      vectors++;
      if (o_mem_valid !== 1'(i & 1)) begin
        errors++;
        $display("FAIL rr_gap cyc=%0d got mv=%b required %0d",
                 i, o_mem_valid, i & 1);
      end
      if ((i & 1) != 0) begin
        vectors++;
        if (o_mem_addr !== (exp_g ? 36'h200 : 36'h100) ||
            o_req0_ready !== ~exp_g || o_req1_ready !== exp_g) begin
          errors++;
          $display("FAIL rr_grant cyc=%0d got addr=%h r0=%b r1=%b required id %0d",
                   i, o_mem_addr, o_req0_ready, o_req1_ready, exp_g);
        end
        sb.push_back('{exp_g, 64'h5000 + 64'(i)});
      end
      tick();
    end
    clr();
    i_mem_ready = 1;
    for (int k = 0; k < 4; k++) begin
      i_mem_resp_valid = 1;
      i_mem_resp_data  = 64'h5000 + 64'(2 * k + 1);
      tick();
    end
    i_mem_resp_valid = 0;
  endtask

  task automatic test_burst_lock();
    i_req1_valid = 1; i_req1_write = 1; i_req1_strob = 8'hFF;
    i_req1_data = 64'd1; i_req1_last = 0; i_req1_addr = 36'h300;
    i_req0_addr = 36'h400; i_req0_last = 1; i_req0_write = 0;
    i_mem_ready = 1;
    #1;
    tick();
    for (int b = 1; b <= 4; b++) begin
      if (b == 2) i_req0_valid = 1;
      i_mem_resp_valid = (b >= 2);
      i_mem_resp_data  = 64'hA000 + 64'(b - 1);
      #1;
      vectors++;
      if (o_mem_valid !== 1'b1 || o_mem_data !== 64'(b) ||
          o_mem_write !== 1'b1 || o_mem_strob !== 8'hFF ||
          o_mem_last !== (b == 4) || o_req1_ready !== 1'b1 ||
          o_req0_ready !== 1'b0) begin
        errors++;
        $display("FAIL lock_beat%0d got mv=%b data=%0d last=%b r0=%b r1=%b required 1 %0d %0d 0 1",
                 b, o_mem_valid, o_mem_data, o_mem_last, o_req0_ready,
                 o_req1_ready, b, b == 4);
      end
      sb.push_back('{1'b1, 64'hA000 + 64'(b)});
      tick();
      i_req1_data = 64'(b + 1);
      i_req1_last = (b + 1 == 4);
    end
    i_req1_valid = 0;
    i_mem_resp_valid = 1; i_mem_resp_data = 64'hA004;
    #1;
    vectors++;
    if (o_mem_valid !== 1'b0 || o_req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL lock_gap got mv=%b r0=%b required 0 0",
               o_mem_valid, o_req0_ready);
    end
    tick();
    i_mem_resp_valid = 0;
    #1;
    vectors++;
    if (o_mem_valid !== 1'b1 || o_mem_addr !== 36'h400 ||
        o_req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL lock_next got mv=%b addr=%h r0=%b required 1 400 1",
               o_mem_valid, o_mem_addr, o_req0_ready);
    end
    sb.push_back('{1'b0, 64'hA005});
    tick();
    i_req0_valid = 0;
    i_mem_resp_valid = 1; i_mem_resp_data = 64'hA005;
    tick();
    clr();
  endtask

  task automatic test_fifo_full();
    logic mv_tab [10] = '{0, 1, 1, 1, 1, 0, 0, 1, 0, 1};
    logic rs_tab [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    int beat = 1;
    int rn   = 1;
    pulse_reset();
    i_req0_valid = 1; i_req0_last = 0; i_req0_addr = 36'h700;
    i_req0_data = 64'd1; i_mem_ready = 1;
    for (int c = 0; c < 10; c++) begin
      i_mem_resp_valid = rs_tab[c];
      i_mem_resp_data  = 64'hA100 + 64'(rn);
      if (rs_tab[c]) rn++;
      #1;
      vectors++;
      if (o_mem_valid !== mv_tab[c] || o_req0_ready !== (c != 0 && mv_tab[c])) begin
        errors++;
        $display("FAIL full_cyc%0d got mv=%b r0=%b required %b",
                 c, o_mem_valid, o_req0_ready, mv_tab[c]);
      end
      if (mv_tab[c]) begin
        vectors++;
        if (o_mem_data !== 64'(beat) || o_mem_last !== (beat == 6)) begin
          errors++;
          $display("FAIL full_data cyc=%0d got %0d last=%b required %0d",
                   c, o_mem_data, o_mem_last, beat);
        end
        sb.push_back('{1'b0, 64'hA100 + 64'(beat)});
      end
      tick();
      if (o_req0_ready === 1'b0 && mv_tab[c]) beat = beat;
      if (mv_tab[c]) beat++;
      i_req0_data = 64'(beat);
      i_req0_last = (beat == 6);
    end
    i_req0_valid = 0; i_req0_last = 0;
    for (int k = 0; k < 4; k++) begin
      i_mem_resp_valid = 1;
      i_mem_resp_data  = 64'hA100 + 64'(rn);
      rn++;
      tick();
    end
    clr();
  endtask

  task automatic test_interleave();
    i_mem_ready = 1;
    i_req0_valid = 1; i_req0_last = 1; i_req0_addr = 36'h500;
    tick();
    #1;
    vectors++;
    if (o_mem_valid !== 1'b1 || o_req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL inter_a got mv=%b r0=%b required 1 1", o_mem_valid, o_req0_ready);
    end
    sb.push_back('{1'b0, 64'hAAAA_0001});
    tick();
    i_req0_valid = 0;
    i_req1_valid = 1; i_req1_last = 1; i_req1_addr = 36'h600;
    tick();
    #1;
    vectors++;
    if (o_mem_valid !== 1'b1 || o_req1_ready !== 1'b1 || o_mem_addr !== 36'h600) begin
      errors++;
      $display("FAIL inter_b got mv=%b r1=%b addr=%h required 1 1 600",
               o_mem_valid, o_req1_ready, o_mem_addr);
    end
    sb.push_back('{1'b1, 64'hBBBB_0002});
    tick();
    i_req1_valid = 0;
    tick();
    tick();
    i_mem_resp_valid = 1; i_mem_resp_data = 64'hAAAA_0001;
    tick();
    i_mem_resp_data = 64'hBBBB_0002;
    tick();
    clr();
  endtask

  task automatic test_orphan_reset();
    #1;
    vectors++;
    if (o_err_orphan !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL orphan_pre got orph=%b busy=%b required 0 0", o_err_orphan, o_busy);
    end
    i_mem_resp_valid = 1; i_mem_resp_data = 64'h0BAD;
    tick();
    i_mem_resp_valid = 0;
    #1;
    vectors++;
    if (o_err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orphan_set got %b required 1", o_err_orphan);
    end
    tick(); tick(); tick();
    #1;
    vectors++;
    if (o_err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orphan_sticky got %b required 1", o_err_orphan);
    end
    i_req1_valid = 1; i_req1_last = 0; i_req1_addr = 36'h900; i_mem_ready = 1;
    tick();
    tick();
    i_rst = 1;
    tick();
    i_rst = 0;
    #1;
    vectors++;
    if ({o_mem_valid, o_req0_ready, o_req1_ready, o_resp0_valid,
         o_resp1_valid, o_busy, o_err_orphan} !== 7'b0 || o_mem_addr !== '0) begin
      errors++;
      $display("FAIL midburst_reset got mv=%b r1=%b busy=%b orph=%b required all 0",
               o_mem_valid, o_req1_ready, o_busy, o_err_orphan);
    end
    i_req1_valid = 0;
    i_mem_resp_valid = 1; i_mem_resp_data = 64'h0DD;
    tick();
    i_mem_resp_valid = 0;
    #1;
    vectors++;
    if (o_err_orphan !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_orphan got orph=%b busy=%b required 1 0",
               o_err_orphan, o_busy);
    end
  endtask

  initial begin
    clr();
    i_rst = 1;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_lock();
    test_fifo_full();
    test_interleave();
    test_orphan_reset();
    tick();
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drained got %0d pending required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
